// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: auto-ranging measurement sequencer producing clear/gate/latch strobes for the BCD edge counter
module freq_gate_ctrl #(
   parameter int TICK_CYC   = 500000,
   parameter int SETTLE_CYC = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       ovf,
   input  logic       low,
   output logic       cnt_clr,
   output logic       gate,
   output logic       cnt_latch,
   output logic [1:0] range,
   output logic [1:0] disp_range,
   output logic       over,
   output logic       busy
);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_DECIDE, S_LATCH} state_t;
   localparam logic [26:0] TICK_LAST   = 27'(TICK_CYC - 1);
   localparam logic [26:0] SETTLE_LAST = 27'(SETTLE_CYC - 1);
   state_t      r_state, w_next;
   logic [26:0] r_cyc;
   logic [6:0]  r_tick;
   logic [1:0]  r_range, r_disp_range;
   logic        r_hyst, r_over, r_clr, r_gate, r_latch, r_busy;
   logic [6:0]  w_tick_last;
   logic        w_gate_done, w_settle_done, w_up, w_dn;
   logic        w_clr, w_gate, w_latch, w_busy;
   assign w_tick_last   = (r_range == 2'd0) ? 7'd99 : (r_range == 2'd1) ? 7'd9 : 7'd0;
   assign w_gate_done   = (r_cyc == TICK_LAST) && (r_tick == w_tick_last);
   assign w_settle_done = (r_cyc == SETTLE_LAST);
   assign w_up          = ovf && (r_range != 2'd2);
   assign w_dn          = low && !ovf && (r_range != 2'd0) && !r_hyst;
   // state register plus registered strobes so every output comes straight from a flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_clr   <= 1'b0;
         r_gate  <= 1'b0;
         r_latch <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_clr   <= w_clr;
         r_gate  <= w_gate;
         r_latch <= w_latch;
         r_busy  <= w_busy;
      end
   end
   // next-state logic; dropping run aborts from any state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = run ? S_CLEAR : S_IDLE;
         S_CLEAR:  w_next = S_GATE;
         S_GATE:   w_next = w_gate_done ? S_SETTLE : S_GATE;
         S_SETTLE: w_next = w_settle_done ? S_DECIDE : S_SETTLE;
         S_DECIDE: w_next = (w_up || w_dn) ? S_CLEAR : S_LATCH;
         S_LATCH:  w_next = S_CLEAR;
         default:  w_next = S_IDLE;
      endcase
      if (!run) w_next = S_IDLE;
   end
   // strobe values for the state being entered, registered above
   always_comb begin
      w_clr   = (w_next == S_CLEAR);
      w_gate  = (w_next == S_GATE);
      w_latch = (w_next == S_LATCH);
      w_busy  = (w_next != S_IDLE);
   end
   // gate timing: cycle counter wraps per tick, tick counter counts ticks; cycle counter is reused for settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cyc  <= '0;
         r_tick <= '0;
      end else if (r_state == S_CLEAR || (r_state == S_GATE && w_gate_done)) begin
         r_cyc  <= '0;
         r_tick <= '0;
      end else if (r_state == S_GATE) begin
         r_cyc  <= (r_cyc == TICK_LAST) ? '0 : r_cyc + 27'd1;
         r_tick <= (r_cyc == TICK_LAST) ? r_tick + 7'd1 : r_tick;
      end else if (r_state == S_SETTLE) begin
         r_cyc  <= r_cyc + 27'd1;
      end
   end
   // auto-ranging with one-shot hysteresis and publication of the latched reading's range
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_range      <= 2'd0;
         r_hyst       <= 1'b0;
         r_disp_range <= 2'd0;
         r_over       <= 1'b0;
      end else begin
         if (r_state == S_DECIDE && run && w_up) begin
            r_range <= r_range + 2'd1;
            r_hyst  <= 1'b1;
         end else if (r_state == S_DECIDE && run && w_dn) begin
            r_range <= r_range - 2'd1;
         end else if (r_state == S_LATCH) begin
            r_hyst  <= 1'b0;
         end
         if (w_next == S_LATCH) begin
            r_disp_range <= r_range;
            r_over       <= ovf;
         end
      end
   end
   assign cnt_clr    = r_clr;
   assign gate       = r_gate;
   assign cnt_latch  = r_latch;
   assign busy       = r_busy;
   assign range      = r_range;
   assign disp_range = r_disp_range;
   assign over       = r_over;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: scoreboard bench for gate widths, latch values/timing, ranging, abort and reset
module tb_freq_gate_ctrl;
   localparam int TICK   = 10;
   localparam int SETTLE = 4;
   logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0, ovf = 1'b0, low = 1'b0;
   logic       cnt_clr, gate, cnt_latch, over, busy;
   logic [1:0] range, disp_range;
   int n_chk = 0, n_err = 0, cyc = 0, g_w = 0, gate_hi_cyc = 0;
   int n_latch = 0, lat_cyc = 0, prev_lat_cyc = 0;
   int q_gate[$];
   int q_lat[$];
   freq_gate_ctrl #(.TICK_CYC(TICK), .SETTLE_CYC(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .ovf(ovf), .low(low),
      .cnt_clr(cnt_clr), .gate(gate), .cnt_latch(cnt_latch),
      .range(range), .disp_range(disp_range), .over(over), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask
   task automatic wait_latch(input int n, input int lim);
      int k = 0;
      while (n_latch < n && k < lim) begin @(posedge clk); #2; k++; end
      if (n_latch < n) chk("timeout_latch", n_latch, n);
   endtask
   task automatic wait_range(input int r, input int lim);
      int k = 0;
      while (int'(range) != r && k < lim) begin @(posedge clk); #2; k++; end
      if (int'(range) != r) chk("timeout_range", int'(range), r);
   endtask
   task automatic wait_gw(input int w, input int lim);
      int k = 0;
      while (g_w != w && k < lim) begin @(negedge clk); #1; k++; end
      if (g_w != w) chk("timeout_gate", g_w, w);
   endtask
   // monitor: gate widths and latched readings popped from the scoreboard queues
   always @(negedge clk) begin
      cyc++;
      chk("strobe_excl", int'((cnt_clr && cnt_latch) || (gate && (cnt_clr || cnt_latch))), 0);
      if (gate) begin
         g_w++;
         gate_hi_cyc = cyc;
      end else if (g_w != 0) begin
         if (q_gate.size() == 0) chk("gate_unexp", g_w, -1);
         else chk("gate_w", g_w, q_gate.pop_front());
         g_w = 0;
      end
      if (cnt_latch) begin
         n_latch++;
         prev_lat_cyc = lat_cyc;
         lat_cyc = cyc;
         chk("latch_dly", cyc - gate_hi_cyc, SETTLE + 2);
         if (q_lat.size() == 0) chk("latch_unexp", int'(disp_range) * 2 + int'(over), -1);
         else chk("latch_val", int'(disp_range) * 2 + int'(over), q_lat.pop_front());
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("rst_clr", cnt_clr, 0);
      chk("rst_gate", gate, 0);
      chk("rst_latch", cnt_latch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_range", range, 0);
      chk("rst_disp", disp_range, 0);
      chk("rst_over", over, 0);
      rst_n = 1'b1;
      @(posedge clk); #2;
      chk("idle_busy", busy, 0);
      q_gate.push_back(1000); q_gate.push_back(1000);
      q_lat.push_back(0); q_lat.push_back(0);
      @(negedge clk); run = 1'b1;
      @(posedge clk); #1;
      chk("start_clr", cnt_clr, 1);
      chk("start_busy", busy, 1);
      @(posedge clk); #1;
      chk("start_gate", gate, 1);
      chk("start_clr_off", cnt_clr, 0);
      wait_latch(2, 2500);
      chk("period", lat_cyc - prev_lat_cyc, 1007);
      ovf = 1'b1;
      q_gate.push_back(1000); q_gate.push_back(100); q_gate.push_back(10);
      q_lat.push_back(5);
      wait_latch(3, 1500);
      chk("up_range", range, 2);
      chk("up_over", over, 1);
      chk("up_disp", disp_range, 2);
      ovf = 1'b0; low = 1'b1;
      q_gate.push_back(10);
      wait_range(1, 100);
      chk("dn_nolatch", n_latch, 3);
      low = 1'b0;
      q_gate.push_back(100); q_lat.push_back(2);
      wait_latch(4, 300);
      chk("dn_range", range, 1);
      low = 1'b1;
      q_gate.push_back(100);
      wait_range(0, 300);
      low = 1'b0; ovf = 1'b1;
      q_gate.push_back(1000);
      wait_range(1, 1200);
      ovf = 1'b0; low = 1'b1;
      q_gate.push_back(100); q_lat.push_back(2);
      wait_latch(5, 300);
      chk("hyst_hold", range, 1);
      q_gate.push_back(100);
      wait_range(0, 300);
      chk("hyst_release", n_latch, 5);
      low = 1'b0;
      q_gate.push_back(500);
      wait_gw(500, 600);
      run = 1'b0;
      @(posedge clk); #1;
      chk("abort_gate", gate, 0);
      chk("abort_busy", busy, 0);
      chk("abort_range", range, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_nolatch", n_latch, 5);
      chk("abort_idle", busy, 0);
      ovf = 1'b1; run = 1'b1;
      q_gate.push_back(1000);
      wait_range(1, 1200);
      ovf = 1'b0;
      q_gate.push_back(50);
      wait_gw(50, 200);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gate", gate, 0);
      chk("arst_busy", busy, 0);
      chk("arst_clr", cnt_clr, 0);
      chk("arst_latch", cnt_latch, 0);
      chk("arst_range", range, 0);
      chk("arst_disp", disp_range, 0);
      chk("arst_over", over, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("arst_nolatch", n_latch, 5);
      rst_n = 1'b1;
      run = 1'b0;
      repeat (3) @(posedge clk);
      chk("q_gate_left", q_gate.size(), 0);
      chk("q_lat_left", q_lat.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement sequencer for the frequency-counter datapath. It generates the clear, gate and latch strobes that drive the BCD edge counter. It auto-ranges the gate time (1 s / 0.1 s / 10 ms) from the counter's overflow and under-range flags, and publishes the range that goes with each latched reading so the display can place the decimal point. It sits between the system clock domain and the counter/display pair and owns all measurement timing.

## Interface
- `TICK_CYC`, 500000: clk cycles per 10 ms base tick (50 MHz). Benches override this.
- `SETTLE_CYC`, 4: clk cycles after the gate closes before flags are sampled, covering the input synchroniser flush. Minimum 1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; 1 = continuous measurement, 0 = idle.
- `ovf` in 1: counter passed 999 during the gate. Valid from SETTLE end until cleared.
- `low` in 1: counter value < 100 (hundreds digit zero). Same validity as `ovf`.
- `cnt_clr` out 1: one-cycle pulse; counter resets to 0.
- `gate` out 1: level; counter counts input edges while high.
- `cnt_latch` out 1: one-cycle pulse; counter copies its value to the display register.
- `range` out 2: current gate range. 0 = 1 s, 1 = 0.1 s, 2 = 10 ms. Code 3 never appears.
- `disp_range` out 2: range belonging to the most recent latched reading.
- `over` out 1: most recent latched reading overflowed at range 2 (out of measurable span).
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, CLEAR, GATE, SETTLE, DECIDE, LATCH.
- IDLE: all strobes low. When `run`=1, go to CLEAR.
- CLEAR: 1 cycle, `cnt_clr`=1, then GATE.
- GATE: `gate`=1 for exactly TICK_CYC·N cycles, with N = 100/10/1 for range 0/1/2, then SETTLE. Use a 27-bit tick-cycle counter plus a 7-bit tick counter; both reload in CLEAR.
- SETTLE: `gate`=0 for SETTLE_CYC cycles, then DECIDE.
- DECIDE: 1 cycle; samples `ovf`/`low`. Priority order:
  1. `ovf` and range<2: range+1, set `hyst`, go to CLEAR. No latch; the reading is discarded.
  2. `ovf` and range==2: go to LATCH with `over` to be set.
  3. `low` and !`ovf` and range>0 and `hyst`==0: range−1, go to CLEAR, discard.
  4. Otherwise: go to LATCH with `over` to be cleared.
- LATCH: 1 cycle, `cnt_latch`=1. `disp_range` and `over` update on the same edge. Clear `hyst`, then go to CLEAR.
- `hyst` blocks one down-range immediately after an up-range, which prevents ping-pong at the 999/1000 boundary.
- `run` falling in any state: next state is IDLE. `gate` drops on that edge, and no latch or range change happens for the aborted measurement. `range` is retained.
- `range` changes only in DECIDE. `disp_range` and `over` change only in LATCH.

## Timing
- Reset values:
  - state IDLE
  - `cnt_clr`=0, `gate`=0, `cnt_latch`=0, `busy`=0
  - `range`=0, `disp_range`=0, `over`=0, `hyst`=0
- Reset mid-gate: `gate` goes low asynchronously and no latch follows.
- All outputs are registered and glitch-free.
- `run` sampled high in IDLE gives `cnt_clr` on the next cycle.
- Accepted measurement period: 1 + TICK_CYC·N + SETTLE_CYC + 1 + 1 cycles.
- Discarded measurement: 1 + TICK_CYC·N + SETTLE_CYC + 1 cycles, then CLEAR.
- `cnt_clr` and `cnt_latch` are never both high, and neither is high while `gate`=1.

## Test plan
All scenarios use TICK_CYC=10, SETTLE_CYC=4.
- **Reset, then `run`=1, `ovf`=0, `low`=0:**
  - `cnt_clr` pulse, then `gate` high exactly 1000 cycles.
  - `cnt_latch` 6 cycles after gate fall (4 settle + DECIDE + LATCH), `disp_range`=0.
  - Period 1007 cycles.
- **`ovf`=1 at every DECIDE from range 0:**
  - Range steps 0→1→2 with no latch; gate widths 1000, 100, 10.
  - Then latch with `over`=1, `disp_range`=2, and range stays 2.
- **At range 2, `low`=1, `ovf`=0:**
  - Range drops to 1 with no latch.
  - Next measurement (gate 100 cycles) latches with `disp_range`=1.
- **Hysteresis:** up-range 0→1 on `ovf`, then `low`=1 at the next DECIDE.
  - Required: no down-range; latch with `disp_range`=1; `hyst` clears.
  - A second `low` then drops range to 0.
- **`run`=0 at gate cycle 500:**
  - `gate`=0 next edge, state IDLE, `busy`=0, no `cnt_latch`, range unchanged.
- **`rst_n` low at gate cycle 50 on range 1:**
  - All outputs go immediately to their reset values, `range`=0.
